// File: rtl/handshake_seq_ctrl.sv
// Request/ack/done handshake sequencer with ack and done timeouts, result pulses and counters.
// All outputs registered: req one cycle after start, pass/fail in the REPORT cycle; no backpressure.
module handshake_seq_ctrl #(
    parameter int ACK_MAX  = 5,
    parameter int DONE_MAX = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ack,
    input  logic       done,
    input  logic [7:0] data_in,
    output logic       req,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [1:0] err_code,
    output logic [7:0] data_out,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ       = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_REPORT    = 3'd4;

    localparam logic [3:0] ACK_LIM  = 4'(ACK_MAX);
    localparam logic [3:0] DONE_LIM = 4'(DONE_MAX);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic       r_req;
    logic       r_busy;
    logic       r_pass;
    logic       r_fail;
    logic [1:0] r_err;
    logic [7:0] r_dout;
    logic [7:0] r_pass_cnt;
    logic [7:0] r_fail_cnt;

    logic [3:0] w_cnt_inc;
    logic [1:0] w_fail_code;

    assign w_cnt_inc = r_cnt + 4'd1;

    // Nonzero code means this cycle ends the transaction as a failure.
    always_comb begin
        w_fail_code = 2'd0;
        case (r_state)
            S_REQ: begin
                if (ack || done) w_fail_code = 2'd1;
            end
            S_WAIT_ACK: begin
                if (!ack && done)                  w_fail_code = 2'd1;
                else if (!ack && r_cnt == ACK_LIM) w_fail_code = 2'd2;
            end
            S_WAIT_DONE: begin
                if (!done && r_cnt == DONE_LIM) w_fail_code = 2'd3;
            end
            default: w_fail_code = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_err      <= 2'd0;
            r_dout     <= 8'd0;
            r_pass_cnt <= 8'd0;
            r_fail_cnt <= 8'd0;
        end else begin
            r_req  <= 1'b0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
            if (w_fail_code != 2'd0) begin
                r_err      <= w_fail_code;
                r_fail     <= 1'b1;
                r_fail_cnt <= r_fail_cnt + 8'd1;
                r_state    <= S_REPORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_err   <= 2'd0;
                            r_cnt   <= 4'd0;
                        end
                    end
                    S_REQ: begin
                        r_cnt   <= 4'd1;
                        r_state <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (ack) begin
                            r_dout  <= data_in;
                            r_cnt   <= 4'd1;
                            r_state <= S_WAIT_DONE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (done) begin
                            r_pass     <= 1'b1;
                            r_pass_cnt <= r_pass_cnt + 8'd1;
                            r_state    <= S_REPORT;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_REPORT: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign req      = r_req;
    assign busy     = r_busy;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign err_code = r_err;
    assign data_out = r_dout;
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_handshake_seq_ctrl.sv
// Bench for handshake_seq_ctrl: cycle table, directed corner transactions, random transactions.
module tb_handshake_seq_ctrl;

    localparam int AM = 5;
    localparam int DM = 10;
    localparam bit H  = 1'b1;
    localparam bit L  = 1'b0;

    logic       clk = 1'b0;
    logic       rst, start, ack, done;
    logic [7:0] data_in;
    logic       req, busy, pass, fail;
    logic [1:0] err_code;
    logic [7:0] data_out, pass_cnt, fail_cnt;

    always #5 clk = ~clk;

    handshake_seq_ctrl #(.ACK_MAX(AM), .DONE_MAX(DM)) dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .done(done), .data_in(data_in),
        .req(req), .busy(busy), .pass(pass), .fail(fail), .err_code(err_code),
        .data_out(data_out), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    typedef struct {
        bit st, ak, dn, rs;
        logic [7:0] din;
        bit e_req, e_busy, e_pass, e_fail;
        logic [1:0] e_err;
        logic [7:0] e_dout, e_pc;
    } vec_t;

    vec_t tbl [0:18];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_pcnt, m_fcnt, m_dout;
    logic [1:0] m_err;
    logic       sc_ack  [0:39];
    logic       sc_done [0:39];
    logic [7:0] sc_data [0:39];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ack = 1'b0; done = 1'b0; data_in = 8'h00;
        tick();
        rst = 1'b0;
        m_pcnt = 8'd0; m_fcnt = 8'd0; m_dout = 8'd0; m_err = 2'd0;
    endtask

    task automatic clear_sc();
        for (int i = 0; i < 40; i++) begin
            sc_ack[i] = 1'b0; sc_done[i] = 1'b0; sc_data[i] = 8'($urandom);
        end
    endtask

    // Offsets are cycles counted from the req cycle (offset 0). The outcome is derived
    // from the protocol rules by scanning the planned ack/done timeline.
    task automatic run_txn(input string nm, input bit hold);
        int rep, a;
        logic [1:0] e;
        bit acc, got;
        acc = 1'b0; a = 0; got = 1'b0; e = 2'd0; rep = 0;
        if (sc_ack[0] || sc_done[0]) begin e = 2'd1; rep = 1; got = 1'b1; end
        for (int j = 1; j <= AM; j++) begin
            if (!got) begin
                if (sc_ack[j])       begin acc = 1'b1; a = j; got = 1'b1; end
                else if (sc_done[j]) begin e = 2'd1; rep = j + 1; got = 1'b1; end
            end
        end
        if (!got) begin e = 2'd2; rep = AM + 1; end
        if (acc) begin
            got = 1'b0;
            for (int m = 1; m <= DM; m++) begin
                if (!got && sc_done[a+m]) begin got = 1'b1; e = 2'd0; rep = a + m + 1; end
            end
            if (!got) begin e = 2'd3; rep = a + DM + 1; end
        end

        start = 1'b1; ack = 1'b0; done = 1'b0;
        tick();
        if (!hold) start = 1'b0;
        for (int j = 0; j < rep; j++) begin
            chk({nm, "/run"}, 48'({req, busy, pass, fail, err_code}),
                48'({j == 0, H, L, L, 2'd0}));
            ack = sc_ack[j]; done = sc_done[j]; data_in = sc_data[j];
            tick();
        end
        ack = 1'b0; done = 1'b0;
        if (acc) m_dout = sc_data[a];
        if (e == 2'd0) m_pcnt = m_pcnt + 8'd1;
        else           m_fcnt = m_fcnt + 8'd1;
        m_err = e;
        chk({nm, "/report"}, 48'({busy, pass, fail, err_code, data_out, pass_cnt, fail_cnt}),
            48'({H, e == 2'd0, e != 2'd0, e, m_dout, m_pcnt, m_fcnt}));
        tick();
        chk({nm, "/idle"}, 48'({req, busy, pass, fail, err_code, data_out}),
            48'({L, L, L, L, m_err, m_dout}));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           st ak dn rs din     req busy pass fail err    dout   pc
        tbl[0]  = '{H, L, L, L, 8'h00,  L, L, L, L, 2'd0, 8'h00, 8'd0};
        tbl[1]  = '{L, L, L, L, 8'h00,  H, H, L, L, 2'd0, 8'h00, 8'd0};
        tbl[2]  = '{L, L, L, L, 8'h00,  L, H, L, L, 2'd0, 8'h00, 8'd0};
        tbl[3]  = '{L, H, L, L, 8'hA5,  L, H, L, L, 2'd0, 8'h00, 8'd0};
        tbl[4]  = '{L, L, L, L, 8'h00,  L, H, L, L, 2'd0, 8'hA5, 8'd0};
        tbl[5]  = '{L, L, H, L, 8'h00,  L, H, L, L, 2'd0, 8'hA5, 8'd0};
        tbl[6]  = '{L, L, L, L, 8'h00,  L, H, H, L, 2'd0, 8'hA5, 8'd1};
        tbl[7]  = '{L, L, L, L, 8'h00,  L, L, L, L, 2'd0, 8'hA5, 8'd1};
        tbl[8]  = '{H, L, L, L, 8'h00,  L, L, L, L, 2'd0, 8'hA5, 8'd1};
        tbl[9]  = '{L, L, L, L, 8'h00,  H, H, L, L, 2'd0, 8'hA5, 8'd1};
        tbl[10] = '{L, L, L, L, 8'h00,  L, H, L, L, 2'd0, 8'hA5, 8'd1};
        tbl[11] = '{H, L, H, H, 8'h00,  L, H, L, L, 2'd0, 8'hA5, 8'd1};
        tbl[12] = '{L, L, L, L, 8'h00,  L, L, L, L, 2'd0, 8'h00, 8'd0};
        tbl[13] = '{H, L, L, L, 8'h00,  L, L, L, L, 2'd0, 8'h00, 8'd0};
        tbl[14] = '{L, L, L, L, 8'h00,  H, H, L, L, 2'd0, 8'h00, 8'd0};
        tbl[15] = '{L, H, L, L, 8'h3C,  L, H, L, L, 2'd0, 8'h00, 8'd0};
        tbl[16] = '{L, L, H, L, 8'h00,  L, H, L, L, 2'd0, 8'h3C, 8'd0};
        tbl[17] = '{L, L, L, L, 8'h00,  L, H, H, L, 2'd0, 8'h3C, 8'd1};
        tbl[18] = '{L, L, L, L, 8'h00,  L, L, L, L, 2'd0, 8'h3C, 8'd1};

        do_reset();
        for (int k = 0; k < 19; k++) begin
            chk($sformatf("tbl[%0d]", k),
                48'({req, busy, pass, fail, err_code, data_out, pass_cnt, fail_cnt}),
                48'({tbl[k].e_req, tbl[k].e_busy, tbl[k].e_pass, tbl[k].e_fail,
                     tbl[k].e_err, tbl[k].e_dout, tbl[k].e_pc, 8'd0}));
            start = tbl[k].st; ack = tbl[k].ak; done = tbl[k].dn;
            rst = tbl[k].rs; data_in = tbl[k].din;
            tick();
        end
        rst = 1'b0; start = 1'b0; ack = 1'b0; done = 1'b0;
        m_pcnt = 8'd1; m_fcnt = 8'd0; m_dout = 8'h3C; m_err = 2'd0;

        clear_sc();                                           run_txn("ack_timeout", 1'b0);
        clear_sc(); sc_ack[5] = 1'b1; sc_done[6] = 1'b1;      run_txn("ack_at_limit", 1'b0);
        clear_sc(); sc_ack[1] = 1'b1;                         run_txn("done_timeout", 1'b0);
        clear_sc(); sc_ack[1] = 1'b1; sc_done[11] = 1'b1;     run_txn("done_at_limit", 1'b0);
        clear_sc(); sc_ack[0] = 1'b1;                         run_txn("ack_in_req", 1'b0);
        clear_sc(); sc_done[1] = 1'b1;                        run_txn("done_before_ack", 1'b0);
        clear_sc(); sc_ack[2] = 1'b1; sc_done[2] = 1'b1; sc_ack[3] = 1'b1; sc_done[4] = 1'b1;
        run_txn("ignored_extras", 1'b0);

        for (int t = 0; t < 80; t++) begin
            int ka, kd;
            clear_sc();
            ka = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, AM + 2));
            sc_ack[ka] = 1'b1;
            if ($urandom_range(0, 3) == 0) sc_done[$urandom_range(0, AM)] = 1'b1;
            kd = int'($urandom_range(1, DM + 2));
            sc_done[ka+kd] = 1'b1;
            if ($urandom_range(0, 2) == 0) sc_done[ka] = 1'b1;
            if ($urandom_range(0, 1) == 0) sc_ack[ka + int'($urandom_range(1, kd))] = 1'b1;
            run_txn("random", 1'b0);
            repeat ($urandom_range(0, 2)) begin
                chk("random/gap", 48'({req, busy, pass, fail}), 48'({L, L, L, L}));
                tick();
            end
        end

        do_reset();
        chk("reset_state", 48'({req, busy, pass, fail, err_code, data_out, pass_cnt, fail_cnt}), 48'd0);
        for (int i = 0; i < 256; i++) begin
            clear_sc(); sc_ack[1] = 1'b1; sc_done[2] = 1'b1;
            run_txn("wrap", 1'b1);
        end
        start = 1'b0;
        chk("wrap_zero", 48'(pass_cnt), 48'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_seq_ctrl.md
HANDSHAKE_SEQ_CTRL -- requirements
Module: handshake_seq_ctrl

Interface
REQ-001 Parameter ACK_MAX, default 5, SHALL set the last cycle after req in which ack is accepted (legal range 1..15).
REQ-002 Parameter DONE_MAX, default 10, SHALL set the last cycle after the ack cycle in which done is accepted (legal range 1..15).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: transaction request, sampled only in IDLE.
REQ-006 Port ack, input, 1 bit: responder acknowledge.
REQ-007 Port done, input, 1 bit: responder completion.
REQ-008 Port data_in, input, 8 bits: responder data, valid in the ack cycle.
REQ-009 Port req, output, 1 bit: request strobe, one cycle per transaction.
REQ-010 Port busy, output, 1 bit: high while a transaction is in progress.
REQ-011 Port pass, output, 1 bit: one-cycle success pulse.
REQ-012 Port fail, output, 1 bit: one-cycle failure pulse.
REQ-013 Port err_code, output, 2 bits: 0 none, 1 protocol order, 2 ack timeout, 3 done timeout.
REQ-014 Port data_out, output, 8 bits: data_in captured in the accepted ack cycle.
REQ-015 Port pass_cnt, output, 8 bits: count of passed transactions.
REQ-016 Port fail_cnt, output, 8 bits: count of failed transactions.

Function
REQ-017 All outputs SHALL be registered; the FSM states SHALL be IDLE, REQ, WAIT_ACK, WAIT_DONE and REPORT.
REQ-018 IDLE: if start=1 in cycle t, the FSM SHALL be in REQ in cycle t+1 with req=1 and busy=1; otherwise it SHALL remain in IDLE.
REQ-019 Entering REQ SHALL clear err_code to 0 and the 4-bit cycle counter cnt to 0.
REQ-020 REQ SHALL last exactly one cycle and SHALL then move to WAIT_ACK with cnt=1; an ack or done sampled during REQ SHALL record err_code=1 and move to REPORT.
REQ-021 WAIT_ACK, ack=1: the FSM SHALL capture data_in into data_out, reset cnt to 1, and move to WAIT_DONE; a done in the same cycle SHALL be ignored.
REQ-022 WAIT_ACK, ack=0 and done=1: the FSM SHALL record err_code=1 and move to REPORT.
REQ-023 WAIT_ACK, ack=0, done=0 and cnt==ACK_MAX: the FSM SHALL record err_code=2 and move to REPORT.
REQ-024 WAIT_ACK, otherwise: cnt SHALL increment.
REQ-025 An ack in the same cycle as cnt==ACK_MAX SHALL be accepted as success.
REQ-026 WAIT_DONE, done=1: the FSM SHALL move to REPORT with err_code=0.
REQ-027 WAIT_DONE, done=0 and cnt==DONE_MAX: the FSM SHALL record err_code=3 and move to REPORT.
REQ-028 WAIT_DONE, otherwise: cnt SHALL increment; ack in WAIT_DONE SHALL be ignored.
REQ-029 REPORT SHALL last one cycle.
REQ-030 REPORT with err_code==0: pass SHALL be 1 and pass_cnt SHALL increment.
REQ-031 REPORT with err_code!=0: fail SHALL be 1 and fail_cnt SHALL increment.
REQ-032 REPORT: busy SHALL be 1, and the FSM SHALL then return to IDLE.
REQ-033 busy SHALL be 1 in REQ, WAIT_ACK, WAIT_DONE and REPORT, and 0 in IDLE.
REQ-034 start SHALL be ignored while busy=1; start held high SHALL launch the next transaction from the first IDLE cycle.
REQ-035 pass_cnt and fail_cnt SHALL wrap from 255 to 0.
REQ-036 err_code and data_out SHALL hold their values until the next REQ entry.
REQ-037 pass and fail SHALL never be high in the same cycle.

Reset
REQ-038 rst=1 at a rising clk edge SHALL force IDLE in any state, including mid-transaction.
REQ-039 On that reset, req, busy, pass, fail, err_code, data_out, pass_cnt, fail_cnt and cnt SHALL all be set to 0.
REQ-040 rst SHALL take priority over every other input in the same cycle; no pass or fail pulse SHALL be emitted for an aborted transaction.

Verification
REQ-041 start=1 at cycle 0, ack=1 with data_in=8'hA5 at cycle 3, done=1 at cycle 5 -> req=1 at cycle 1, pass=1 at cycle 6, data_out=8'hA5, pass_cnt=1, busy=0 at cycle 7.
REQ-042 Defaults, start at cycle 0, ack never asserted -> fail=1 with err_code=2 at cycle 7; an ack at cycle 6 instead -> accepted, no fail.
REQ-043 Ack at cycle 2, done never asserted -> fail=1 with err_code=3 at cycle 13, fail_cnt=1.
REQ-044 Ack during the req cycle (cycle 1) -> fail with err_code=1 at cycle 2; done at cycle 2 with no ack -> fail with err_code=1 at cycle 3.
REQ-045 rst=1 at cycle 3 during WAIT_ACK -> all outputs 0 at cycle 4, no pass or fail pulse; start at cycle 5 -> req at cycle 6.
REQ-046 256 consecutive passing transactions with start held high -> pass_cnt returns to 0 and the next transaction's req follows REPORT by exactly one IDLE cycle.
